// File: rtl/aes_key_expand.sv
// AES key schedule for 128/192/256-bit keys: one schedule word per cycle into a
// 60-word store, with a registered round-key read port for the cipher core.
module aes_key_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key_i,
    input  logic [1:0]   key_len,
    input  logic [3:0]   round_key_no,
    output logic [127:0] round_key,
    output logic [3:0]   rounds_total,
    output logic         busy,
    output logic         ready
);

    typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TBL[(11'd2047 - {b, 3'b000}) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [2:0]     pos_q, pos_d;      // idx_q mod Nk, avoids a divider for Nk=6
    logic [3:0]     nk_q, nk_d;
    logic [3:0]     nr_q, nr_d;
    logic           busy_q, busy_d;
    logic           ready_q, ready_d;
    logic [127:0]   round_key_q;
    logic [31:0]    w_q [0:59];

    logic           accept_s;
    logic           wr_en_s;
    logic [3:0]     nk_sel_s;
    logic [3:0]     nr_sel_s;
    logic [31:0]    prev_s;
    logic [31:0]    back_s;
    logic [31:0]    temp_s;
    logic [31:0]    new_word_s;
    logic [5:0]     last_idx_s;
    logic [3:0]     rd_k_s;
    logic [5:0]     rd_base_s;
    logic [127:0]   rk_s;

    // Key-length decode for a new request
    always_comb begin
        nk_sel_s = 4'd4;
        nr_sel_s = 4'd10;
        case (key_len)
            2'b00:   begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; end
            2'b01:   begin nk_sel_s = 4'd6; nr_sel_s = 4'd12; end
            2'b10:   begin nk_sel_s = 4'd8; nr_sel_s = 4'd14; end
            default: begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; end
        endcase
    end

    assign accept_s   = (state_q == ST_IDLE) && start && (key_len != 2'b11);
    assign prev_s     = w_q[idx_q - 6'd1];
    assign back_s     = w_q[idx_q - {2'b00, nk_q}];
    assign last_idx_s = {nr_q, 2'b00} + 6'd3;
    assign new_word_s = back_s ^ temp_s;

    // Schedule word transform
    always_comb begin
        temp_s = prev_s;
        if (pos_q == 3'd0) begin
            temp_s = sub_word({prev_s[7:0], prev_s[31:8]}) ^ {24'h000000, rcon_q};
        end else if ((nk_q == 4'd8) && (pos_q == 3'd4)) begin
            temp_s = sub_word(prev_s);
        end else begin
            temp_s = prev_s;
        end
    end

    // FSM next state and datapath control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        pos_d   = pos_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        wr_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXPAND;
                    idx_d   = {2'b00, nk_sel_s};
                    rcon_d  = 8'h01;
                    pos_d   = 3'd0;
                    nk_d    = nk_sel_s;
                    nr_d    = nr_sel_s;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                wr_en_s = 1'b1;
                idx_d   = idx_q + 6'd1;
                pos_d   = (({1'b0, pos_q} + 4'd1) == nk_q) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                if (idx_q == last_idx_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Round-key read mux; the index clamp only keeps the address in range
    always_comb begin
        rd_k_s    = (round_key_no > 4'd14) ? 4'd14 : round_key_no;
        rd_base_s = {rd_k_s, 2'b00};
        if (round_key_no <= nr_q) begin
            rk_s = {w_q[rd_base_s + 6'd3], w_q[rd_base_s + 6'd2],
                    w_q[rd_base_s + 6'd1], w_q[rd_base_s]};
        end else begin
            rk_s = 128'h0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 6'd0;
            rcon_q      <= 8'h01;
            pos_q       <= 3'd0;
            nk_q        <= 4'd4;
            nr_q        <= 4'd0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            round_key_q <= 128'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rcon_q      <= rcon_d;
            pos_q       <= pos_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            round_key_q <= rk_s;
        end
    end

    // Word store: deliberately not reset, writes blocked while reset is high
    always_ff @(posedge clk) begin
        if (!reset && accept_s) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < nk_sel_s) begin
                    w_q[j] <= key_i[32*j +: 32];
                end
            end
        end else if (!reset && wr_en_s) begin
            w_q[idx_q] <= new_word_s;
        end
    end

    assign round_key    = round_key_q;
    assign rounds_total = nr_q;
    assign busy         = busy_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-expansion vectors,
// converted from FIPS byte order to the packed little-endian port layout.
module tb_aes_key_expand;

    logic         clk;
    logic         reset;
    logic         start;
    logic [255:0] key_i;
    logic [1:0]   key_len;
    logic [3:0]   round_key_no;
    logic [127:0] round_key;
    logic [3:0]   rounds_total;
    logic         busy;
    logic         ready;

    int checks = 0;
    int errors = 0;

    aes_key_expand dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key_i        (key_i),
        .key_len      (key_len),
        .round_key_no (round_key_no),
        .round_key    (round_key),
        .rounds_total (rounds_total),
        .busy         (busy),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] fips;
    } rk_vec_t;

    rk_vec_t tab [13];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [31:0] bs(input logic [31:0] w);
        bs = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] mk_key(input logic [255:0] f);
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = bs(f[255-32*j -: 32]);
        return k;
    endfunction

    function automatic logic [127:0] mk_rk(input logic [127:0] f);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[32*j +: 32] = bs(f[127-32*j -: 32]);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start an expansion and count edges until ready; optionally pulse start
    // (with a different key) mid-expansion, which must be ignored.
    task automatic expand(input logic [255:0] fkey, input logic [1:0] len,
                          input int pulse_at, output int cycles);
        int n;
        key_i   = mk_key(fkey);
        key_len = len;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", ready, 1'b0);
        n = 0;
        while (!ready && n < 200) begin
            if (n == pulse_at) begin
                start   = 1'b1;
                key_len = 2'b10;
                key_i   = ~mk_key(fkey);
            end
            tick();
            start   = 1'b0;
            key_len = len;
            key_i   = mk_key(fkey);
            n++;
        end
        cycles = n;
        chk("busy_at_done", busy, 1'b0);
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] rk);
        round_key_no = idx;
        tick();
        rk = round_key;
    endtask

    initial begin
        int cyc;
        logic [127:0] rk;

        tab[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tab[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tab[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tab[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tab[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tab[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tab[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tab[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tab[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tab[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        tab[11] = '{4'd15, 128'h0};
        tab[12] = '{4'd11, 128'h0};

        reset        = 1'b1;
        start        = 1'b0;
        key_i        = '0;
        key_len      = 2'b00;
        round_key_no = 4'd0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_round_key", round_key, 128'h0);
        chk("rst_rounds_total", rounds_total, 4'd0);
        reset = 1'b0;
        tick();

        // AES-128, full schedule read back-to-back from index 10 down to 0
        expand(KEY128, 2'b00, -1, cyc);
        chk("aes128_cycles", cyc, 40);
        chk("aes128_ready", ready, 1'b1);
        chk("aes128_rounds", rounds_total, 4'd10);
        for (int i = 0; i < 13; i++) begin
            round_key_no = tab[i].idx;
            tick();
            chk($sformatf("aes128_rk%0d", tab[i].idx), round_key, mk_rk(tab[i].fips));
        end

        // Reserved key length in IDLE with ready=1 is ignored
        key_i   = mk_key(KEY256);
        key_len = 2'b11;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        key_len = 2'b00;
        chk("rsv_busy", busy, 1'b0);
        chk("rsv_ready", ready, 1'b1);
        chk("rsv_rounds", rounds_total, 4'd10);
        read_rk(4'd10, rk);
        chk("rsv_rk10", rk, mk_rk(tab[0].fips));

        // AES-192
        expand(KEY192, 2'b01, -1, cyc);
        chk("aes192_cycles", cyc, 46);
        chk("aes192_rounds", rounds_total, 4'd12);
        read_rk(4'd12, rk);
        chk("aes192_w51", rk[127:96], bs(32'h01002202));
        read_rk(4'd0, rk);
        chk("aes192_w0", rk[31:0], bs(32'h8e73b0f7));
        read_rk(4'd13, rk);
        chk("aes192_rk13_zero", rk, 128'h0);

        // AES-256
        expand(KEY256, 2'b10, -1, cyc);
        chk("aes256_cycles", cyc, 52);
        chk("aes256_rounds", rounds_total, 4'd14);
        read_rk(4'd14, rk);
        chk("aes256_w59", rk[127:96], bs(32'h706c631e));

        // Re-key to AES-128 with a start pulse during EXPAND
        expand(KEY128, 2'b00, 10, cyc);
        chk("ign_cycles", cyc, 40);
        chk("ign_rounds", rounds_total, 4'd10);
        read_rk(4'd10, rk);
        chk("ign_rk10", rk, mk_rk(tab[0].fips));
        read_rk(4'd5, rk);
        chk("ign_rk5", rk, mk_rk(tab[5].fips));

        // Reset 20 cycles into an AES-256 expansion
        key_i   = mk_key(KEY256);
        key_len = 2'b10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        chk("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b0);
        chk("abort_round_key", round_key, 128'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_ready_hold", ready, 1'b0);
        chk("abort_busy_hold", busy, 1'b0);

        expand(KEY128, 2'b00, -1, cyc);
        chk("post_abort_cycles", cyc, 40);
        read_rk(4'd10, rk);
        chk("post_abort_rk10", rk, mk_rk(tab[0].fips));
        read_rk(4'd15, rk);
        chk("post_abort_rk15", rk, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
